// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store sequencer.
// Size encodings, FSM state type and the size/alignment/extension helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10
    } lsu_byte_state_t;

    // Number of byte transfers for an access size; the unused code 11 behaves as a word.
    function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = addr_lo[0];
            default: m = (addr_lo != 2'b00);
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                                input logic [31:0] raw);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {{24{raw[7] & ~uns}}, raw[7:0]};
            SZ_HALF: r = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_byte_lane_reg.sv
// 32-bit load staging register with a single-byte write port and a clear.
// Clear wins over a byte write landing in the same cycle.
module lsu_byte_lane_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [1:0]  lane,
    input  logic [7:0]  wr_byte,
    output logic [31:0] q
);

    logic [31:0] data_r;

    // Staging storage: async clear, sync clear, then lane write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= 32'h0000_0000;
        end else if (clr) begin
            data_r <= 32'h0000_0000;
        end else if (wr_en) begin
            data_r[{lane, 3'b000} +: 8] <= wr_byte;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/lsu_byte_ctrl.sv
// Serialises one byte/half/word load or store onto a byte-wide memory port
// and returns the assembled, extended load word.
module lsu_byte_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    lsu_byte_state_t   state_r, next_state_s;
    logic              we_r, uns_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [1:0]        k_r, k_inc_s;

    logic              accept_s, mis_s, ack_s, last_s, stage_wr_s;
    logic [31:0]       stage_q_s, merged_s;

    logic              mem_req_n_s, mem_we_n_s, resp_valid_n_s, resp_err_n_s;
    logic [ADDR_W-1:0] mem_addr_n_s;
    logic [7:0]        mem_wdata_n_s;
    logic [31:0]       resp_rdata_n_s;

    logic              mem_req_r, mem_we_r, resp_valid_r, resp_err_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic [31:0]       resp_rdata_r;

    assign accept_s   = (state_r == ST_IDLE) && req_valid;
    assign mis_s      = is_misaligned(req_size, req_addr[1:0]);
    assign ack_s      = (state_r == ST_XFER) && mem_ack;
    assign last_s     = ({1'b0, k_r} == (bytes_for_size(size_r) - 3'd1));
    assign k_inc_s    = k_r + 2'd1;
    assign stage_wr_s = ack_s && !we_r;

    // Held low while reset is asserted so no request appears accepted.
    assign req_ready  = (state_r == ST_IDLE) && rst;

    lsu_byte_lane_reg u_stage (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept_s),
        .wr_en   (stage_wr_s),
        .lane    (k_r),
        .wr_byte (mem_rdata),
        .q       (stage_q_s)
    );

    // Staging value including the byte arriving this cycle, so the response can register on the last ack.
    always_comb begin
        merged_s = stage_q_s;
        if (stage_wr_s) begin
            merged_s[{k_r, 3'b000} +: 8] = mem_rdata;
        end else begin
            merged_s = stage_q_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = mis_s ? ST_RESP : ST_XFER;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (ack_s && last_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_XFER;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Request latch and byte counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            k_r     <= 2'b00;
        end else if (accept_s) begin
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            size_r  <= req_size;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            k_r     <= 2'b00;
        end else if (ack_s && !last_s) begin
            k_r     <= k_inc_s;
        end
    end

    // Next values of the registered outputs, decoded from state and the events of this cycle.
    always_comb begin
        mem_req_n_s    = 1'b0;
        mem_we_n_s     = 1'b0;
        mem_addr_n_s   = {ADDR_W{1'b0}};
        mem_wdata_n_s  = 8'h00;
        resp_valid_n_s = 1'b0;
        resp_err_n_s   = 1'b0;
        resp_rdata_n_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && mis_s) begin
                    resp_valid_n_s = 1'b1;
                    resp_err_n_s   = 1'b1;
                end else if (accept_s) begin
                    mem_req_n_s   = 1'b1;
                    mem_we_n_s    = req_we;
                    mem_addr_n_s  = req_addr;
                    mem_wdata_n_s = req_wdata[7:0];
                end else begin
                    mem_req_n_s   = 1'b0;
                end
            end
            ST_XFER: begin
                if (ack_s && last_s) begin
                    resp_valid_n_s = 1'b1;
                    resp_rdata_n_s = we_r ? 32'h0000_0000 : extend_load(size_r, uns_r, merged_s);
                end else if (ack_s) begin
                    mem_req_n_s   = 1'b1;
                    mem_we_n_s    = we_r;
                    mem_addr_n_s  = addr_r + ADDR_W'(k_inc_s);
                    mem_wdata_n_s = wdata_r[{k_inc_s, 3'b000} +: 8];
                end else begin
                    mem_req_n_s   = 1'b1;
                    mem_we_n_s    = we_r;
                    mem_addr_n_s  = addr_r + ADDR_W'(k_r);
                    mem_wdata_n_s = wdata_r[{k_r, 3'b000} +: 8];
                end
            end
            ST_RESP: begin
                resp_valid_n_s = 1'b0;
            end
            default: begin
                resp_valid_n_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 8'h00;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            mem_req_r    <= mem_req_n_s;
            mem_we_r     <= mem_we_n_s;
            mem_addr_r   <= mem_addr_n_s;
            mem_wdata_r  <= mem_wdata_n_s;
            resp_valid_r <= resp_valid_n_s;
            resp_err_r   <= resp_err_n_s;
            resp_rdata_r <= resp_rdata_n_s;
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_lsu_byte_ctrl.sv
// Self-checking bench for lsu_byte_ctrl: directed vector table, reset corner
// cases and randomized transactions against a byte-array memory model.
module tb_lsu_byte_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [logic [31:0]];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    lsu_byte_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int n_bytes(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = n_bytes(size);
        return (addr % n) != 0;
    endfunction

    // Fill any unknown memory bytes with random data so loads have defined contents.
    task automatic ensure_mem(input logic [31:0] addr, input int n);
        for (int i = 0; i < n; i++) begin
            if (!mem_model.exists(addr + i)) mem_model[addr + i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Reference load result: little-endian assembly then arithmetic sign/zero extension.
    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        int n;
        logic [31:0] v;
        n = n_bytes(size);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v + (32'(mem_model[addr + i]) << (8 * i));
        if (n == 1 && !uns && v >= 32'd128)   v = v + 32'hFFFF_FF00;
        if (n == 2 && !uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // One request: start in the idle cycle, ack each byte after 'delay' wait cycles (negative = random).
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                           input logic exp_err, input logic [31:0] exp_rdata);
        int n;
        int d;
        logic [31:0] sh;
        n = n_bytes(size);
        tick();
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
        if (exp_err) begin
            chk("err_resp_valid", 32'(resp_valid), 32'd1);
            chk("err_resp_err", 32'(resp_err), 32'd1);
            chk("err_mem_req", 32'(mem_req), 32'd0);
            chk("err_rdata", resp_rdata, 32'h0);
            chk("err_ready", 32'(req_ready), 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                d = (delay < 0) ? $urandom_range(0, 2) : delay;
                for (int w = 0; w <= d; w++) begin
                    chk("mem_req", 32'(mem_req), 32'd1);
                    chk("mem_addr", mem_addr, addr + i);
                    chk("mem_we", 32'(mem_we), 32'(we));
                    sh = wdata >> (8 * i);
                    if (we) chk("mem_wdata", 32'(mem_wdata), 32'(sh[7:0]));
                    chk("busy_resp_valid", 32'(resp_valid), 32'd0);
                    chk("busy_ready", 32'(req_ready), 32'd0);
                    if (w == d) begin
                        mem_ack = 1'b1;
                        mem_rdata = we ? 8'($urandom_range(0, 255)) : mem_model[addr + i];
                    end else begin
                        mem_ack = 1'b0;
                        mem_rdata = 8'($urandom_range(0, 255));
                    end
                    tick();
                    mem_ack = 1'b0;
                    mem_rdata = 8'($urandom_range(0, 255));
                end
                if (we) mem_model[addr + i] = sh[7:0];
            end
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_err", 32'(resp_err), 32'd0);
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_mem_req", 32'(mem_req), 32'd0);
            chk("resp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic        mis;
        logic [31:0] exp;

        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0100; req_wdata = 32'hDEAD_BEEF;

        // Reset held with a pending request: everything quiet, nothing accepted.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_err", 32'(resp_err), 32'd0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        tick();
        chk("post_rst_mem_req", 32'(mem_req), 32'd0);

        mem_model[32'h0000_0203] = 8'hAA;
        mem_model[32'h0000_0010] = 8'h34;
        mem_model[32'h0000_0011] = 8'h82;
        mem_model[32'h0000_0104] = 8'h01;
        mem_model[32'h0000_0105] = 8'h80;
        mem_model[32'h0000_0106] = 8'hFF;
        mem_model[32'h0000_0107] = 8'h7E;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1234_5678, 0, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1'b0, 32'h1234_5678};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_0000, 3, 1'b0, 32'hFFFF_FFAA};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0000_0000, 0, 1'b0, 32'h0000_00AA};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0000_0000, 1, 1'b0, 32'hFFFF_8234};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0000_0000, 0, 1'b0, 32'h0000_8234};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_BEEF, 0, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0000_0000, 0, 1'b1, 32'h0000_0000};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0000_0000, 0, 1'b0, 32'h7EFF_8001};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 32'h0000_0104, 32'h0000_0000, 2, 1'b0, 32'h7EFF_8001};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'hFFFF_FF5C, 1, 1'b0, 32'h0000_0000};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_0000, 0, 1'b0, 32'h0000_005C};

        for (int v = 0; v < 12; v++) begin
            run_txn(vecs[v].we, vecs[v].size, vecs[v].uns, vecs[v].addr, vecs[v].wdata,
                    vecs[v].delay, vecs[v].exp_err, vecs[v].exp_rdata);
        end

        // An ack with no request outstanding must be ignored.
        tick();
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_mem_req", 32'(mem_req), 32'd0);
        chk("stray_ack_resp_valid", 32'(resp_valid), 32'd0);
        chk("stray_ack_ready", 32'(req_ready), 32'd1);

        // Reset during a word store after its second ack: abandoned with no response.
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0000; req_wdata = 32'hAABB_CCDD;
        tick();
        req_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("mid_mem_req", 32'(mem_req), 32'd1);
        chk("mid_mem_addr", mem_addr, 32'h0000_0002);
        chk("mid_mem_wdata", 32'(mem_wdata), 32'h0000_00BB);
        rst = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        mem_model[32'h0000_0000] = 8'hDD;
        mem_model[32'h0000_0001] = 8'hCC;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("after_rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("after_rst_mem_req", 32'(mem_req), 32'd0);
        end
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_005A, 0, 1'b0, 32'h0000_0000);
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 32'h0000_005A);

        // Randomized traffic, including addresses at the top of the address space.
        for (int t = 0; t < 60; t++) begin
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : 32'h0000_0300 + 32'($urandom_range(0, 15));
            mis  = misaligned(size, addr);
            exp  = 32'h0;
            if (!mis && !we) begin
                ensure_mem(addr, n_bytes(size));
                exp = model_load(size, uns, addr);
            end
            run_txn(we, size, uns, addr, $urandom, -1, mis, exp);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
